// File: rtl/conv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : conv_pkg
// Description : Shared definitions for the N-to-8 Tx down-converter: lane
//               width mode encodings, serializer FSM state type and the
//               lane-count helper used when a word is loaded.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package conv_pkg;

    // Width mode encodings (same encoding as PCLK); 2'b11 behaves as MODE_8
    localparam logic [1:0] MODE_32 = 2'b00;
    localparam logic [1:0] MODE_16 = 2'b01;
    localparam logic [1:0] MODE_8  = 2'b10;

    // Serializer FSM states
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // Number of active byte lanes for a given mode and input word width.
    // 32-bit mode is capped by the physical word width.
    function automatic logic [2:0] lanes(input logic [1:0] mode, input int unsigned in_w);
        logic [2:0] l;
        case (mode)
            MODE_32: l = (in_w >= 32) ? 3'd4 : 3'(in_w / 8);
            MODE_16: l = 3'd2;
            default: l = 3'd1;
        endcase
        return l;
    endfunction

endpackage
`default_nettype wire

// File: rtl/conv_ntx8_param_if.sv
`default_nettype none
// ============================================================================
// Module      : conv_ntx8_param_if
// Description : Word-side and byte-side valid/ready bus of the N-to-8 Tx
//               down-converter.
//   master : link layer / downstream side (drives in_*, out_ready)
//   slave  : converter side (drives in_ready, out_*)
//   in_data  [IN_W]   parallel word       in_k  [IN_W/8] K flag per byte
//   in_valid / in_ready                   word handshake
//   out_data [8]      serialised byte     out_k          K flag of out_data
//   out_valid / out_ready                 byte handshake
// Revision    : 1.0 - initial release
// ============================================================================
interface conv_ntx8_param_if #(
    parameter int IN_W = 32
);
    logic [IN_W-1:0]   in_data;
    logic [IN_W/8-1:0] in_k;
    logic              in_valid;
    logic              in_ready;
    logic [7:0]        out_data;
    logic              out_k;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output in_data, in_k, in_valid, out_ready,
        input  in_ready, out_data, out_k, out_valid
    );

    modport slave (
        input  in_data, in_k, in_valid, out_ready,
        output in_ready, out_data, out_k, out_valid
    );
endinterface
`default_nettype wire

// File: rtl/conv_fifo.sv
`default_nettype none
// ============================================================================
// Module      : conv_fifo
// Description : Synchronous FIFO holding {k, data} words ahead of the
//               serializer. Show-ahead: head_o is the oldest entry.
//   clk, rst   clock, synchronous active-high flush
//   push_i     write din_i (caller guarantees not full)
//   pop_i      drop head (caller guarantees not empty)
//   din_i      entry to write          head_o   oldest entry
//   count_o    occupancy, 0..DEPTH
// Revision    : 1.0 - initial release
// ============================================================================
module conv_fifo #(
    parameter  int W     = 40,
    parameter  int DEPTH = 2,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  wire logic          clk,
    input  wire logic          rst,
    input  wire logic          push_i,
    input  wire logic          pop_i,
    input  wire logic [W-1:0]  din_i,
    output logic      [W-1:0]  head_o,
    output logic      [CW-1:0] count_o
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;

    // Storage needs no reset: only entries counted in count_q are ever read.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/conv_ntx8_param.sv
`default_nettype none
// ============================================================================
// Module      : conv_ntx8_param
// Description : Parametrised N-to-8 down-converter for the PHY Tx path.
//               Words are queued in conv_fifo, then serialised MS active
//               byte first with their per-byte K flags.
//   CLK    Tx byte clock            RESET  synchronous active-high reset
//   ENB    block enable (low freezes all state, in_ready forced low)
//   PCLK   width mode: 00 32-bit, 01 16-bit, 1x 8-bit (sampled on load)
//   bus    conv_ntx8_param_if.slave word in / byte out handshakes
// Revision    : 1.0 - initial release
// ============================================================================
module conv_ntx8_param #(
    parameter int IN_W  = 32,
    parameter int DEPTH = 2
) (
    input  wire logic       CLK,
    input  wire logic       RESET,
    input  wire logic       ENB,
    input  wire logic [1:0] PCLK,
    conv_ntx8_param_if.slave bus
);
    import conv_pkg::*;

    localparam int KW = IN_W / 8;
    localparam int FW = IN_W + KW;
    localparam int CW = $clog2(DEPTH + 1);

    // ------------------------------------------------------------------
    // Input FIFO
    // ------------------------------------------------------------------
    logic [CW-1:0] w_count;
    logic [FW-1:0] w_head;
    logic          w_empty;
    logic          w_in_ready;
    logic          w_push;
    logic          w_load;

    // in_ready depends only on the registered count, never on a same-cycle
    // pop, so a full FIFO frees its slot one cycle after the load.
    assign w_in_ready = ENB && !RESET && (w_count < CW'(DEPTH));
    assign w_push     = bus.in_valid && w_in_ready;
    assign w_empty    = (w_count == '0);

    conv_fifo #(
        .W     (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (CLK),
        .rst     (RESET),
        .push_i  (w_push),
        .pop_i   (w_load),
        .din_i   ({bus.in_k, bus.in_data}),
        .head_o  (w_head),
        .count_o (w_count)
    );

    // ------------------------------------------------------------------
    // Serializer state
    // ------------------------------------------------------------------
    state_t          state_q, state_d;
    logic [1:0]      lane_q,  lane_d;
    logic [IN_W-1:0] word_q,  word_d;
    logic [KW-1:0]   k_q,     k_d;

    logic            w_pop_byte;
    logic [2:0]      w_lanes;
    logic [3:0][7:0] w_bytes;
    logic [3:0]      w_k_pad;

    assign w_pop_byte = ENB && (state_q == ST_SHIFT) && bus.out_ready;
    assign w_lanes    = lanes(PCLK, IN_W);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= ST_IDLE;
            lane_q  <= 2'd0;
            word_q  <= '0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            word_q  <= word_d;
            k_q     <= k_d;
        end
    end

    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        word_d  = word_q;
        k_d     = k_q;
        w_load  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (ENB && !w_empty) begin
                    w_load  = 1'b1;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (w_pop_byte) begin
                    if (lane_q != 2'd0) begin
                        lane_d = lane_q - 2'd1;
                    end else if (!w_empty) begin
                        // last lane consumed and another word waits: no bubble
                        w_load = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Mode is latched here only, so PCLK changes never affect a word in flight.
        if (w_load) begin
            word_d = w_head[IN_W-1:0];
            k_d    = w_head[FW-1:IN_W];
            lane_d = 2'(w_lanes - 3'd1);
        end
    end

    // Pad to four lanes so a single lane index works for every IN_W.
    assign w_bytes = 32'(word_q);
    assign w_k_pad = 4'(k_q);

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = (state_q == ST_SHIFT);
    assign bus.out_data  = w_bytes[lane_q];
    assign bus.out_k     = w_k_pad[lane_q];

endmodule
`default_nettype wire

// File: tb/tb_conv_ntx8_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_conv_ntx8_param
// Description : Directed self-checking bench for conv_ntx8_param
//               (IN_W = 32, DEPTH = 2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_conv_ntx8_param;

    logic       clk;
    logic       RESET;
    logic       ENB;
    logic [1:0] PCLK;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [8:0] rx_q[$];
    int         rx_t[$];

    conv_ntx8_param_if #(.IN_W(32)) bus ();

    conv_ntx8_param #(
        .IN_W  (32),
        .DEPTH (2)
    ) dut (
        .CLK   (clk),
        .RESET (RESET),
        .ENB   (ENB),
        .PCLK  (PCLK),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Record every byte handshake that completes on the following rising edge.
    always @(negedge clk) begin
        if (!RESET && ENB && bus.out_valid && bus.out_ready) begin
            rx_q.push_back({bus.out_k, bus.out_data});
            rx_t.push_back(cyc);
        end
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout bench did not complete");
        $fatal(1);
    end

    task automatic push_word(input logic [31:0] d, input logic [3:0] k, output int t_acc);
        bit ok;
        ok = 1'b0;
        bus.in_data  = d;
        bus.in_k     = k;
        bus.in_valid = 1'b1;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge clk);
            ok = bus.in_ready;
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        t_acc = cyc;
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL push_accept word %h: accepted=%0d required=1", d, ok);
        end
    endtask

    task automatic wait_bytes(input int n, input int limit);
        int c;
        c = 0;
        while (rx_q.size() < n && c < limit) begin
            @(posedge clk);
            #1;
            c++;
        end
        n_cmp++;
        if (rx_q.size() < n) begin
            n_err++;
            $display("FAIL byte_wait got=%0d bytes required=%0d", rx_q.size(), n);
        end
    endtask

    task automatic test_reset();
        RESET         = 1'b1;
        ENB           = 1'b1;
        PCLK          = 2'b00;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_k      = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL rst_in_ready got=%b exp=0", bus.in_ready); end
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid got=%b exp=0", bus.out_valid); end
        n_cmp++; if (bus.out_data !== 8'h00) begin n_err++; $display("FAIL rst_out_data got=%h exp=00", bus.out_data); end
        n_cmp++; if (bus.out_k !== 1'b0) begin n_err++; $display("FAIL rst_out_k got=%b exp=0", bus.out_k); end
        @(posedge clk);
        #1;
        RESET = 1'b0;
        @(negedge clk);
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL rst_release_in_ready got=%b exp=1", bus.in_ready); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_stream();
        logic [8:0] exp [4];
        logic [8:0] got;
        int t;
        exp = '{9'h00F, 9'h000, 9'h0FF, 9'h055};
        rx_q.delete(); rx_t.delete();
        PCLK = 2'b00;
        bus.out_ready = 1'b1;
        push_word(32'h0F00FF55, 4'b0000, t);
        wait_bytes(4, 20);
        for (int i = 0; i < 4; i++) begin
            got = (i < rx_q.size()) ? rx_q[i] : 9'h1FF;
            n_cmp++;
            if (got !== exp[i]) begin n_err++; $display("FAIL stream_byte%0d got=%h exp=%h", i, got, exp[i]); end
            n_cmp++;
            if (i >= rx_t.size() || rx_t[i] != t + 1 + i) begin
                n_err++;
                $display("FAIL stream_timing%0d got_cycle=%0d exp_cycle=%0d", i, (i < rx_t.size()) ? rx_t[i] : -1, t + 1 + i);
            end
        end
        repeat (5) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL stream_idle_valid got=%b exp=0", bus.out_valid); end
        n_cmp++; if (rx_q.size() != 4) begin n_err++; $display("FAIL stream_count got=%0d exp=4", rx_q.size()); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        logic [8:0] exp [8];
        logic [8:0] got;
        int t;
        exp = '{9'h0AA, 9'h00F, 9'h000, 9'h0FF, 9'h10F, 9'h0F0, 9'h0FF, 9'h000};
        rx_q.delete(); rx_t.delete();
        PCLK = 2'b00;
        push_word(32'hAA0F00FF, 4'b0000, t);
        push_word(32'h0FF0FF00, 4'b1000, t);
        wait_bytes(8, 30);
        for (int i = 0; i < 8; i++) begin
            got = (i < rx_q.size()) ? rx_q[i] : 9'h1FF;
            n_cmp++;
            if (got !== exp[i]) begin n_err++; $display("FAIL b2b_byte%0d got=%h exp=%h", i, got, exp[i]); end
        end
        n_cmp++;
        if (rx_t.size() < 8 || rx_t[7] != rx_t[0] + 7) begin
            n_err++;
            $display("FAIL b2b_contiguous span=%0d exp=7", (rx_t.size() >= 8) ? rx_t[7] - rx_t[0] : -1);
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_mode_switch();
        logic [8:0] exp [7];
        logic [8:0] got;
        int t;
        exp = '{9'h030, 9'h0EA, 9'h0AA, 9'h011, 9'h022, 9'h033, 9'h044};
        rx_q.delete(); rx_t.delete();
        PCLK = 2'b01;
        push_word(32'h30EA30EA, 4'b0000, t);
        wait_bytes(2, 20);
        PCLK = 2'b10;
        push_word(32'hAAFF00AA, 4'b0000, t);
        wait_bytes(3, 20);
        PCLK = 2'b00;
        push_word(32'h11223344, 4'b0000, t);
        wait_bytes(4, 20);
        PCLK = 2'b10;   // mid-word change must not shorten the word in flight
        wait_bytes(7, 20);
        repeat (6) @(posedge clk);
        #1;
        n_cmp++; if (rx_q.size() != 7) begin n_err++; $display("FAIL mode_count got=%0d exp=7", rx_q.size()); end
        for (int i = 0; i < 7; i++) begin
            got = (i < rx_q.size()) ? rx_q[i] : 9'h1FF;
            n_cmp++;
            if (got !== exp[i]) begin n_err++; $display("FAIL mode_byte%0d got=%h exp=%h", i, got, exp[i]); end
        end
        PCLK = 2'b00;
    endtask

    task automatic test_backpressure();
        logic [8:0] exp [12];
        logic [8:0] got;
        int t;
        exp = '{9'h001, 9'h002, 9'h003, 9'h004,
                9'h005, 9'h106, 9'h007, 9'h008,
                9'h009, 9'h00A, 9'h00B, 9'h10C};
        rx_q.delete(); rx_t.delete();
        PCLK = 2'b00;
        bus.out_ready = 1'b0;
        push_word(32'h01020304, 4'b0000, t);
        push_word(32'h05060708, 4'b0100, t);
        push_word(32'h090A0B0C, 4'b0001, t);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL full_in_ready cyc%0d got=%b exp=0", i, bus.in_ready); end
            n_cmp++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL full_out_valid cyc%0d got=%b exp=1", i, bus.out_valid); end
            n_cmp++; if (bus.out_data !== 8'h01) begin n_err++; $display("FAIL full_hold_data cyc%0d got=%h exp=01", i, bus.out_data); end
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        wait_bytes(12, 40);
        for (int i = 0; i < 12; i++) begin
            got = (i < rx_q.size()) ? rx_q[i] : 9'h1FF;
            n_cmp++;
            if (got !== exp[i]) begin n_err++; $display("FAIL drain_byte%0d got=%h exp=%h", i, got, exp[i]); end
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_enb();
        logic [8:0] exp [4];
        logic [8:0] got;
        int t;
        exp = '{9'h0A1, 9'h0A2, 9'h0A3, 9'h0A4};
        rx_q.delete(); rx_t.delete();
        PCLK = 2'b00;
        bus.out_ready = 1'b1;
        push_word(32'hA1A2A3A4, 4'b0000, t);
        wait_bytes(2, 20);
        ENB = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_cmp++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL enb_valid_hold cyc%0d got=%b exp=1", i, bus.out_valid); end
            n_cmp++; if (bus.out_data !== 8'hA3) begin n_err++; $display("FAIL enb_data_hold cyc%0d got=%h exp=a3", i, bus.out_data); end
            n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL enb_in_ready cyc%0d got=%b exp=0", i, bus.in_ready); end
            @(posedge clk);
            #1;
        end
        ENB = 1'b1;
        wait_bytes(4, 20);
        repeat (6) @(posedge clk);
        #1;
        n_cmp++; if (rx_q.size() != 4) begin n_err++; $display("FAIL enb_count got=%0d exp=4", rx_q.size()); end
        for (int i = 0; i < 4; i++) begin
            got = (i < rx_q.size()) ? rx_q[i] : 9'h1FF;
            n_cmp++;
            if (got !== exp[i]) begin n_err++; $display("FAIL enb_byte%0d got=%h exp=%h", i, got, exp[i]); end
        end
    endtask

    task automatic test_midreset();
        logic [8:0] got;
        int t;
        rx_q.delete(); rx_t.delete();
        PCLK = 2'b00;
        bus.out_ready = 1'b1;
        push_word(32'hB1B2B3B4, 4'b1111, t);
        wait_bytes(2, 20);
        RESET = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL midrst_valid got=%b exp=0", bus.out_valid); end
        n_cmp++; if (bus.out_data !== 8'h00) begin n_err++; $display("FAIL midrst_data got=%h exp=00", bus.out_data); end
        @(posedge clk);
        #1;
        RESET = 1'b0;
        @(negedge clk);
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL midrst_in_ready got=%b exp=1", bus.in_ready); end
        repeat (8) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL midrst_idle_valid got=%b exp=0", bus.out_valid); end
        n_cmp++; if (rx_q.size() != 2) begin n_err++; $display("FAIL midrst_count got=%0d exp=2", rx_q.size()); end
        got = (rx_q.size() > 1) ? rx_q[1] : 9'h1FF;
        n_cmp++; if (got !== 9'h1B2) begin n_err++; $display("FAIL midrst_last_byte got=%h exp=1b2", got); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_back_to_back();
        test_mode_switch();
        test_backpressure();
        test_enb();
        test_midreset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
